// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and flush controller for the 5-stage pipeline.
// Drives stall/bubble/flush/forward selects and keeps saturating perf counters.
module pipeline_ctrl #(
    parameter int REG_BITS     = 5,
    parameter int FWD_WB       = 1,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic                ex_valid,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_reg_we,
    input  logic                ex_mem_re,
    input  logic                mem_valid,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic                mem_reg_we,
    input  logic                wb_valid,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic                wb_reg_we,
    input  logic                jump,
    input  logic                perf_clr,
    output logic [1:0]          fwd_a_src,
    output logic [1:0]          fwd_b_src,
    output logic                if_stall,
    output logic                id_stall,
    output logic                ex_bubble,
    output logic                flush_if,
    output logic                flush_id,
    output logic                busy,
    output logic [CNT_W-1:0]    perf_cycles,
    output logic [CNT_W-1:0]    perf_stalls,
    output logic [CNT_W-1:0]    perf_flushes,
    output logic [CNT_W-1:0]    perf_retired
);

    typedef enum logic [1:0] {
        S_RUN,
        S_LDSTALL,
        S_FLUSH
    } state_t;

    localparam logic [2:0] LD_INIT = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);

    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] stl_q, stl_d;
    logic [CNT_W-1:0] fls_q, fls_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic ex_a, mem_a, wb_a;
    logic ex_b, mem_b, wb_b;
    logic loaduse, redirect;
    logic ld_cyc, flush_evt;

    function automatic logic hit(
        input logic                v,
        input logic                we,
        input logic [REG_BITS-1:0] rd,
        input logic [REG_BITS-1:0] rs,
        input logic                used
    );
        return v & we & (rd != '0) & (rd == rs) & used;
    endfunction

    function automatic logic [1:0] sel(
        input logic e,
        input logic m,
        input logic w
    );
        if (e)
            return 2'd1;
        if (m)
            return 2'd2;
        if (FWD_WB != 0 && w)
            return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [CNT_W-1:0] bump(
        input logic [CNT_W-1:0] v,
        input logic             en,
        input logic             clr
    );
        if (clr)
            return '0;
        if (en && v != '1)
            return v + 1'b1;
        return v;
    endfunction

    always_comb begin
        ex_a  = hit(ex_valid, ex_reg_we, ex_rd, id_rs1, id_rs1_used);
        mem_a = hit(mem_valid, mem_reg_we, mem_rd, id_rs1, id_rs1_used);
        wb_a  = hit(wb_valid, wb_reg_we, wb_rd, id_rs1, id_rs1_used);
        ex_b  = hit(ex_valid, ex_reg_we, ex_rd, id_rs2, id_rs2_used);
        mem_b = hit(mem_valid, mem_reg_we, mem_rd, id_rs2, id_rs2_used);
        wb_b  = hit(wb_valid, wb_reg_we, wb_rd, id_rs2, id_rs2_used);
        fwd_a_src = sel(ex_a, mem_a, wb_a);
        fwd_b_src = sel(ex_b, mem_b, wb_b);
    end

    assign loaduse  = run & id_valid & ex_mem_re & (ex_a | ex_b);
    assign redirect = run & jump;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        if_stall  = 1'b0;
        id_stall  = 1'b0;
        ex_bubble = 1'b0;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        ld_cyc    = 1'b0;
        flush_evt = 1'b0;
        if (!run) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
        end else if (redirect) begin
            // a redirect overrides any pending load stall or flush
            flush_if  = 1'b1;
            flush_id  = 1'b1;
            flush_evt = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = S_FLUSH;
                cnt_d   = FL_INIT;
            end else begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        end else begin
            unique case (state_q)
                S_LDSTALL: begin
                    if_stall  = 1'b1;
                    id_stall  = 1'b1;
                    ex_bubble = 1'b1;
                    ld_cyc    = 1'b1;
                    cnt_d     = cnt_q - 3'd1;
                    if (cnt_q == 3'd1)
                        state_d = S_RUN;
                end
                S_FLUSH: begin
                    flush_if = 1'b1;
                    cnt_d    = cnt_q - 3'd1;
                    if (cnt_q == 3'd1)
                        state_d = S_RUN;
                end
                default: begin
                    if (loaduse) begin
                        if_stall  = 1'b1;
                        id_stall  = 1'b1;
                        ex_bubble = 1'b1;
                        ld_cyc    = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = S_LDSTALL;
                            cnt_d   = LD_INIT;
                        end
                    end
                end
            endcase
        end
        if (reset) begin
            if_stall  = 1'b0;
            id_stall  = 1'b0;
            ex_bubble = 1'b0;
            flush_if  = 1'b0;
            flush_id  = 1'b0;
            ld_cyc    = 1'b0;
            flush_evt = 1'b0;
        end
    end

    always_comb begin
        cyc_d = bump(cyc_q, run, perf_clr);
        stl_d = bump(stl_q, ld_cyc, perf_clr);
        fls_d = bump(fls_q, flush_evt, perf_clr);
        ret_d = bump(ret_q, run & wb_valid, perf_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            cyc_q   <= '0;
            stl_q   <= '0;
            fls_q   <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            stl_q   <= stl_d;
            fls_q   <= fls_d;
            ret_q   <= ret_d;
        end
    end

    assign busy         = (state_q != S_RUN);
    assign perf_cycles  = cyc_q;
    assign perf_stalls  = stl_q;
    assign perf_flushes = fls_q;
    assign perf_retired = ret_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl: two configurations share one stimulus
// stream and are each compared against a behavioural model every cycle.
module tb_pipeline_ctrl;

    localparam int FW0 = 1, LL0 = 3, FC0 = 2, CW0 = 16;
    localparam int FW1 = 0, LL1 = 1, FC1 = 3, CW1 = 4;

    logic clk = 1'b0;
    logic reset, run, id_valid, id_rs1_used, id_rs2_used;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic ex_valid, ex_reg_we, ex_mem_re;
    logic mem_valid, mem_reg_we, wb_valid, wb_reg_we;
    logic jump, perf_clr;

    logic [1:0] fa [2];
    logic [1:0] fb [2];
    logic ifs [2];
    logic ids [2];
    logic exb [2];
    logic fli [2];
    logic fld [2];
    logic bsy [2];
    logic [CW0-1:0] c0 [4];
    logic [CW1-1:0] c1 [4];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int sl [2];
    int fl [2];
    longint cnt [2][4];

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .REG_BITS(5), .FWD_WB(FW0), .LOAD_LAT(LL0),
        .FLUSH_CYCLES(FC0), .CNT_W(CW0)
    ) dut0 (
        .clk(clk), .reset(reset), .run(run),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .ex_mem_re(ex_mem_re),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
        .jump(jump), .perf_clr(perf_clr),
        .fwd_a_src(fa[0]), .fwd_b_src(fb[0]),
        .if_stall(ifs[0]), .id_stall(ids[0]), .ex_bubble(exb[0]),
        .flush_if(fli[0]), .flush_id(fld[0]), .busy(bsy[0]),
        .perf_cycles(c0[0]), .perf_stalls(c0[1]),
        .perf_flushes(c0[2]), .perf_retired(c0[3])
    );

    pipeline_ctrl #(
        .REG_BITS(5), .FWD_WB(FW1), .LOAD_LAT(LL1),
        .FLUSH_CYCLES(FC1), .CNT_W(CW1)
    ) dut1 (
        .clk(clk), .reset(reset), .run(run),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .ex_mem_re(ex_mem_re),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_we(wb_reg_we),
        .jump(jump), .perf_clr(perf_clr),
        .fwd_a_src(fa[1]), .fwd_b_src(fb[1]),
        .if_stall(ifs[1]), .id_stall(ids[1]), .ex_bubble(exb[1]),
        .flush_if(fli[1]), .flush_id(fld[1]), .busy(bsy[1]),
        .perf_cycles(c1[0]), .perf_stalls(c1[1]),
        .perf_flushes(c1[2]), .perf_retired(c1[3])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt_out(input int i, input int k);
        if (i == 0)
            return 32'(c0[k]);
        return 32'(c1[k]);
    endfunction

    // Operand source: the youngest stage that writes the register wins.
    function automatic logic [1:0] ref_fwd(input logic [4:0] rs,
                                           input logic used, input int fw);
        if (!used || rs == 0)
            return 2'd0;
        if (ex_valid && ex_reg_we && ex_rd == rs)
            return 2'd1;
        if (mem_valid && mem_reg_we && mem_rd == rs)
            return 2'd2;
        if (fw != 0 && wb_valid && wb_reg_we && wb_rd == rs)
            return 2'd3;
        return 2'd0;
    endfunction

    task automatic step(input int i);
        int ll, fc, fw;
        longint mx;
        logic ld;
        logic e_ifs, e_ids, e_exb, e_fli, e_fld;
        string p;
        ll = (i == 0) ? LL0 : LL1;
        fc = (i == 0) ? FC0 : FC1;
        fw = (i == 0) ? FW0 : FW1;
        mx = (i == 0) ? ((64'd1 << CW0) - 1) : ((64'd1 << CW1) - 1);
        p = $sformatf("d%0d.", i);

        check({p, "fwd_a"}, 32'(fa[i]), 32'(ref_fwd(id_rs1, id_rs1_used, fw)));
        check({p, "fwd_b"}, 32'(fb[i]), 32'(ref_fwd(id_rs2, id_rs2_used, fw)));

        ld = id_valid && ex_valid && ex_mem_re && ex_reg_we && ex_rd != 0 &&
             ((id_rs1_used && id_rs1 == ex_rd) ||
              (id_rs2_used && id_rs2 == ex_rd));
        {e_ifs, e_ids, e_exb, e_fli, e_fld} = '0;
        if (reset) begin
        end else if (!run) begin
            e_ifs = 1'b1;
            e_ids = 1'b1;
        end else if (jump) begin
            e_fli = 1'b1;
            e_fld = 1'b1;
        end else if (fl[i] > 0) begin
            e_fli = 1'b1;
        end else if (sl[i] > 0 || ld) begin
            e_ifs = 1'b1;
            e_ids = 1'b1;
            e_exb = 1'b1;
        end
        check({p, "if_stall"}, 32'(ifs[i]), 32'(e_ifs));
        check({p, "id_stall"}, 32'(ids[i]), 32'(e_ids));
        check({p, "ex_bubble"}, 32'(exb[i]), 32'(e_exb));
        check({p, "flush_if"}, 32'(fli[i]), 32'(e_fli));
        check({p, "flush_id"}, 32'(fld[i]), 32'(e_fld));
        check({p, "busy"}, 32'(bsy[i]), 32'(sl[i] > 0 || fl[i] > 0));
        check({p, "perf_cycles"}, cnt_out(i, 0), 32'(cnt[i][0]));
        check({p, "perf_stalls"}, cnt_out(i, 1), 32'(cnt[i][1]));
        check({p, "perf_flushes"}, cnt_out(i, 2), 32'(cnt[i][2]));
        check({p, "perf_retired"}, cnt_out(i, 3), 32'(cnt[i][3]));

        if (reset) begin
            sl[i] = 0;
            fl[i] = 0;
            for (int k = 0; k < 4; k++)
                cnt[i][k] = 0;
        end else begin
            if (run) begin
                if (jump) begin
                    fl[i] = fc - 1;
                    sl[i] = 0;
                    if (cnt[i][2] < mx) cnt[i][2]++;
                end else if (fl[i] > 0) begin
                    fl[i]--;
                end else if (sl[i] > 0) begin
                    sl[i]--;
                    if (cnt[i][1] < mx) cnt[i][1]++;
                end else if (ld) begin
                    sl[i] = ll - 1;
                    if (cnt[i][1] < mx) cnt[i][1]++;
                end
                if (cnt[i][0] < mx) cnt[i][0]++;
                if (wb_valid && cnt[i][3] < mx) cnt[i][3]++;
            end
            if (perf_clr)
                for (int k = 0; k < 4; k++)
                    cnt[i][k] = 0;
        end
    endtask

    task automatic drive_random();
        reset       = ($urandom_range(0, 99) < 2);
        run         = ($urandom_range(0, 99) < 85);
        id_valid    = ($urandom_range(0, 3) != 0);
        id_rs1      = 5'($urandom_range(0, 3));
        id_rs2      = 5'($urandom_range(0, 3));
        id_rs1_used = ($urandom_range(0, 3) != 0);
        id_rs2_used = ($urandom_range(0, 3) != 0);
        ex_valid    = ($urandom_range(0, 3) != 0);
        ex_rd       = 5'($urandom_range(0, 3));
        ex_reg_we   = ($urandom_range(0, 3) != 0);
        ex_mem_re   = ($urandom_range(0, 9) < 4);
        mem_valid   = ($urandom_range(0, 3) != 0);
        mem_rd      = 5'($urandom_range(0, 3));
        mem_reg_we  = ($urandom_range(0, 3) != 0);
        wb_valid    = ($urandom_range(0, 9) < 6);
        wb_rd       = 5'($urandom_range(0, 3));
        wb_reg_we   = ($urandom_range(0, 3) != 0);
        jump        = ($urandom_range(0, 9) == 0);
        perf_clr    = ($urandom_range(0, 99) < 3);
    endtask

    initial begin
        {reset, run, id_valid, id_rs1_used, id_rs2_used} = 5'b10000;
        {id_rs1, id_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {ex_valid, ex_reg_we, ex_mem_re} = '0;
        {mem_valid, mem_reg_we, wb_valid, wb_reg_we, jump, perf_clr} = '0;
        for (int i = 0; i < 2; i++) begin
            sl[i] = 0;
            fl[i] = 0;
            for (int k = 0; k < 4; k++)
                cnt[i][k] = 0;
        end
        repeat (2) @(posedge clk);
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            cyc = n;
            drive_random();
            if (n == 0)
                reset = 1'b1;
            #3;
            step(0);
            step(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Parametrised hazard, forwarding and flush controller for the 5-stage core pipeline (IF/ID/EX/MEM/WB).
- Replaces the ad-hoc forwarding mux selection and the fixed jump-only stall logic in the core top.
- Adds load-use stall with configurable load latency, multi-cycle redirect flush, an optional WB forwarding source and saturating performance counters.
- Sits beside the stage modules and drives their stall, bubble, flush and forwarding-select inputs.

Parameters:
REG_BITS, 5, register index width
FWD_WB, 1, 1 = WB stage is a third forwarding source; 0 = only EX and MEM
LOAD_LAT, 1, cycles from load issue in EX until data is forwardable (1..7)
FLUSH_CYCLES, 1, cycles flush_if is held after a redirect (1..7)
CNT_W, 32, width of each perf counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
run  in  1  pipeline enable; low = hold everything
id_valid  in  1  ID holds a real instruction
id_rs1  in  REG_BITS  ID source register 1
id_rs2  in  REG_BITS  ID source register 2
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
ex_valid  in  1  EX holds a real instruction
ex_rd  in  REG_BITS  EX destination
ex_reg_we  in  1  EX writes rd
ex_mem_re  in  1  EX instruction is a load
mem_valid, mem_rd, mem_reg_we  in  1/REG_BITS/1  MEM-stage destination info
wb_valid, wb_rd, wb_reg_we  in  1/REG_BITS/1  WB-stage destination info; wb_valid also marks retirement
jump  in  1  EX redirect taken (branch/jal/jalr)
perf_clr  in  1  clear all perf counters
fwd_a_src  out  2  rs1 operand source: 0 regfile, 1 EX, 2 MEM, 3 WB
fwd_b_src  out  2  rs2 operand source, same encoding
if_stall  out  1  hold PC and IF register
id_stall  out  1  hold ID register
ex_bubble  out  1  insert NOP into EX
flush_if  out  1  squash instruction in IF
flush_id  out  1  squash instruction in ID
busy  out  1  state != RUN
perf_cycles, perf_stalls, perf_flushes, perf_retired  out  CNT_W each  perf counters

Behaviour:
- State machine, registered: RUN, LDSTALL, FLUSH. Reset -> RUN, counters 0, internal down-counter 0.
- Forwarding (combinational) for each operand, with match = stage valid & we & rd!=0 & rd==rs & rs_used:
  - priority EX(1) > MEM(2) > WB(3, only if FWD_WB=1) > 0.
  - rs==0 always gives 0.
  - EX match where ex_mem_re=1 still reports 1; the stall below guarantees it is never consumed.
- Load-use (loaduse) = run & id_valid & ex_valid & ex_mem_re & ex_reg_we & ex_rd!=0 & (rs1 match | rs2 match).
- Jump (redirect) = run & jump. Redirect has priority over load-use in the same cycle.
- RUN:
  - redirect: flush_if=flush_id=1 this cycle, stalls 0. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1.
  - else loaduse: if_stall=id_stall=ex_bubble=1 this cycle. If LOAD_LAT>1, go to LDSTALL with cnt=LOAD_LAT-1.
- LDSTALL: if_stall=id_stall=ex_bubble=1; cnt decrements; go to RUN when cnt reaches 1→0.
  - A redirect arriving in LDSTALL aborts the stall: outputs behave as RUN-redirect and go to FLUSH or RUN.
- FLUSH: flush_if=1, flush_id=0; cnt decrements; go to RUN when cnt reaches 0. A further redirect reloads cnt=FLUSH_CYCLES-1.
- run=0: if_stall=id_stall=1, ex_bubble=flush_*=0, state and cnt frozen, counters frozen.
- Reset mid-stall or mid-flush: next cycle is RUN with all outputs deasserted.
- busy = (state != RUN). All stall/flush outputs are 0 in reset.
- Counters, saturating at 2^CNT_W-1, incrementing only when run=1:
  - cycles: +1 every cycle.
  - stalls: +1 per cycle if_stall due to loaduse/LDSTALL.
  - flushes: +1 per redirect event (not per flush cycle).
  - retired: +1 when wb_valid.
- perf_clr zeroes all counters next cycle and wins over a simultaneous increment. Counters are registered outputs: one-cycle latency.

Test Plan:
- Forward priority: rs1=5 with EX rd=5 we=1 and MEM rd=5 -> fwd_a_src=1. Remove EX -> 2. Only WB rd=5 -> 3 (0 when FWD_WB=0). rs1=0 -> 0.
- Load-use, LOAD_LAT=3: EX lw rd=7, ID uses rs2=7 -> if_stall/id_stall/ex_bubble high exactly 3 cycles, busy high cycles 2-3, perf_stalls +3.
- Redirect, FLUSH_CYCLES=2: jump pulse -> cycle0 flush_if=flush_id=1, cycle1 flush_if=1 only, cycle2 all 0; perf_flushes +1.
- Simultaneous jump and load-use -> flush only, no stall, perf_stalls unchanged. Jump during LDSTALL -> stall aborted same cycle.
- run=0 for 4 cycles mid-LDSTALL -> state and counters frozen, stall resumes the remaining cycles after run=1.
- Counters with CNT_W=4: 20 cycles -> perf_cycles=15 (saturated). perf_clr with wb_valid=1 -> perf_retired=0 next cycle. Reset during FLUSH -> all outputs 0 next cycle.
